wb_port_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_port_arbiter_if.sv | 64 ++++++
 rtl/wb_fifo2.sv | 47 ++++
 rtl/wb_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the write-back port arbiter.
// Holds the buffered unit-result record and the FIFO/starvation limits.
package wb_arb_pkg;

    localparam int WB_FIFO_DEPTH   = 2;
    localparam int WB_STARVE_LIMIT = 3;

    typedef struct packed {
        logic        reg_we;
        logic        hi_we;
        logic        lo_we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
    } wb_entry;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between pipeline/mul-div unit and the write-back arbiter.
// master = surrounding core, slave = arbiter.
interface wb_port_arbiter_if;

    logic        p_valid;
    logic        p_reg_we;
    logic        p_hi_we;
    logic        p_lo_we;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic [31:0] p_pc;
    logic        p_stall;

    logic        m_valid;
    logic        m_ready;
    logic        m_reg_we;
    logic        m_hi_we;
    logic        m_lo_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_pc;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    logic [3:0]  dbg_reg_we;
    logic [4:0]  dbg_waddr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_pc;

    modport master (
        output p_valid, p_reg_we, p_hi_we, p_lo_we,
        output p_waddr, p_wdata, p_hi, p_lo, p_pc,
        input  p_stall,
        output m_valid, m_reg_we, m_hi_we, m_lo_we,
        output m_waddr, m_wdata, m_hi, m_lo, m_pc,
        input  m_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  hi_we, lo_we, hi_wdata, lo_wdata,
        input  dbg_reg_we, dbg_waddr, dbg_wdata, dbg_pc
    );

    modport slave (
        input  p_valid, p_reg_we, p_hi_we, p_lo_we,
        input  p_waddr, p_wdata, p_hi, p_lo, p_pc,
        output p_stall,
        input  m_valid, m_reg_we, m_hi_we, m_lo_we,
        input  m_waddr, m_wdata, m_hi, m_lo, m_pc,
        output m_ready,
        output rf_we, rf_waddr, rf_wdata,
        output hi_we, lo_we, hi_wdata, lo_wdata,
        output dbg_reg_we, dbg_waddr, dbg_wdata, dbg_pc
    );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry FIFO buffering mul/div results awaiting a write-back slot.
// Push while full is accepted only when a pop happens in the same cycle.
module wb_fifo2
    import wb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  wb_entry    din,
    output wb_entry    head,
    output logic [1:0] count
);

    wb_entry mem [WB_FIFO_DEPTH];
    logic    rd_ptr;
    logic    wr_ptr;
    logic    do_push;
    logic    do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count < 2'(WB_FIFO_DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: pipeline owns RF/HI/LO, buffered unit results fill gaps.
// Define WB_DEBUG_TRACE_EN to drive the dbg_* retire trace; otherwise it is tied to 0.
module wb_port_arbiter
    import wb_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    wb_entry    m_in;
    wb_entry    head;
    logic [1:0] count;
    logic [1:0] starve;
    logic [1:0] starve_nxt;
    logic       stall_q;
    logic       m_rdy;
    logic       push;
    logic       head_vld;
    logic       pv;
    logic       conflict;
    logic       drain;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    always_comb begin
        m_in        = '0;
        m_in.reg_we = bus.m_reg_we;
        m_in.hi_we  = bus.m_hi_we;
        m_in.lo_we  = bus.m_lo_we;
        m_in.addr   = bus.m_waddr;
        m_in.data   = bus.m_wdata;
        m_in.hi     = bus.m_hi;
        m_in.lo     = bus.m_lo;
        m_in.pc     = bus.m_pc;
    end

    assign m_rdy    = rst && (count < 2'(WB_FIFO_DEPTH));
    assign push     = bus.m_valid && m_rdy;
    assign head_vld = (count != 2'd0);
    assign pv       = rst && bus.p_valid;

    assign conflict = pv && ((head.reg_we && bus.p_reg_we) ||
                             (head.hi_we  && bus.p_hi_we)  ||
                             (head.lo_we  && bus.p_lo_we));
    assign drain    = head_vld && (!conflict || stall_q);

    wb_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (drain),
        .din   (m_in),
        .head  (head),
        .count (count)
    );

    // A head left waiting is always a conflict deferral; stall cycles always drain.
    always_comb begin
        starve_nxt = starve;
        if (!head_vld || drain)
            starve_nxt = 2'd0;
        else if (starve != 2'(WB_STARVE_LIMIT))
            starve_nxt = starve + 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve  <= 2'd0;
            stall_q <= 1'b0;
        end else begin
            starve  <= starve_nxt;
            stall_q <= (starve_nxt == 2'(WB_STARVE_LIMIT));
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        hi_we    = 1'b0;
        hi_wdata = '0;
        lo_we    = 1'b0;
        lo_wdata = '0;
        if (pv && bus.p_reg_we) begin
            rf_we    = 1'b1;
            rf_waddr = bus.p_waddr;
            rf_wdata = bus.p_wdata;
        end else if (drain && head.reg_we) begin
            rf_we    = 1'b1;
            rf_waddr = head.addr;
            rf_wdata = head.data;
        end
        if (rf_waddr == 5'd0)
            rf_we = 1'b0;
        if (pv && bus.p_hi_we) begin
            hi_we    = 1'b1;
            hi_wdata = bus.p_hi;
        end else if (drain && head.hi_we) begin
            hi_we    = 1'b1;
            hi_wdata = head.hi;
        end
        if (pv && bus.p_lo_we) begin
            lo_we    = 1'b1;
            lo_wdata = bus.p_lo;
        end else if (drain && head.lo_we) begin
            lo_we    = 1'b1;
            lo_wdata = head.lo;
        end
    end

    assign bus.m_ready  = m_rdy;
    assign bus.p_stall  = stall_q;
    assign bus.rf_we    = rf_we;
    assign bus.rf_waddr = rf_waddr;
    assign bus.rf_wdata = rf_wdata;
    assign bus.hi_we    = hi_we;
    assign bus.hi_wdata = hi_wdata;
    assign bus.lo_we    = lo_we;
    assign bus.lo_wdata = lo_wdata;

`ifdef WB_DEBUG_TRACE_EN
    logic [4:0]  dbg_waddr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_pc;

    always_comb begin
        dbg_waddr = '0;
        dbg_wdata = '0;
        dbg_pc    = '0;
        if (pv) begin
            dbg_waddr = bus.p_waddr;
            dbg_wdata = bus.p_wdata;
            dbg_pc    = bus.p_pc;
        end else if (drain) begin
            dbg_waddr = head.addr;
            dbg_wdata = head.data;
            dbg_pc    = head.pc;
        end
    end

    assign bus.dbg_reg_we = {4{rf_we}};
    assign bus.dbg_waddr  = dbg_waddr;
    assign bus.dbg_wdata  = dbg_wdata;
    assign bus.dbg_pc     = dbg_pc;
`else
    logic unused_trace;
    assign unused_trace   = ^{head.pc, bus.p_pc};
    assign bus.dbg_reg_we = '0;
    assign bus.dbg_waddr  = '0;
    assign bus.dbg_wdata  = '0;
    assign bus.dbg_pc     = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter.
// Each row is one clock cycle; outputs are sampled at the falling edge.
module tb_wb_port_arbiter;

    typedef struct {
        logic        pv, prw, phw, plw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        mv, mrw, mhw, mlw;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_mr, e_st, e_rf;
        logic [4:0]  e_ra;
        logic [31:0] e_rd;
        logic        e_hi;
        logic [31:0] e_hd;
        logic        e_lo;
        logic [31:0] e_ld;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   dbg_bad;
    vec_t vq[$];

    wb_port_arbiter_if ifc ();

    wb_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic pv, prw, phw, plw,
        input logic [4:0] pa, input logic [31:0] pd,
        input logic mv, mrw, mhw, mlw,
        input logic [4:0] ma, input logic [31:0] md,
        input logic e_mr, e_st,
        input logic e_rf, input logic [4:0] e_ra, input logic [31:0] e_rd,
        input logic e_hi, input logic [31:0] e_hd,
        input logic e_lo, input logic [31:0] e_ld);
        vec_t r;
        r.pv = pv; r.prw = prw; r.phw = phw; r.plw = plw;
        r.pa = pa; r.pd = pd;
        r.mv = mv; r.mrw = mrw; r.mhw = mhw; r.mlw = mlw;
        r.ma = ma; r.md = md;
        r.e_mr = e_mr; r.e_st = e_st;
        r.e_rf = e_rf; r.e_ra = e_ra; r.e_rd = e_rd;
        r.e_hi = e_hi; r.e_hd = e_hd;
        r.e_lo = e_lo; r.e_ld = e_ld;
        return r;
    endfunction

    task automatic drive(input vec_t e);
        ifc.p_valid  = e.pv;
        ifc.p_reg_we = e.prw;
        ifc.p_hi_we  = e.phw;
        ifc.p_lo_we  = e.plw;
        ifc.p_waddr  = e.pa;
        ifc.p_wdata  = e.pd;
        ifc.p_hi     = e.pd + 32'd1;
        ifc.p_lo     = e.pd + 32'd2;
        ifc.p_pc     = 32'h100;
        ifc.m_valid  = e.mv;
        ifc.m_reg_we = e.mrw;
        ifc.m_hi_we  = e.mhw;
        ifc.m_lo_we  = e.mlw;
        ifc.m_waddr  = e.ma;
        ifc.m_wdata  = e.md;
        ifc.m_hi     = e.md + 32'd1;
        ifc.m_lo     = e.md + 32'd2;
        ifc.m_pc     = 32'h200;
    endtask

    task automatic check(input string name, input vec_t e);
        logic ok;
        ok = (ifc.m_ready === e.e_mr) && (ifc.p_stall === e.e_st) &&
             (ifc.rf_we === e.e_rf) && (ifc.hi_we === e.e_hi) &&
             (ifc.lo_we === e.e_lo);
        if (e.e_rf)
            ok = ok && (ifc.rf_waddr === e.e_ra) && (ifc.rf_wdata === e.e_rd);
        if (e.e_hi)
            ok = ok && (ifc.hi_wdata === e.e_hd);
        if (e.e_lo)
            ok = ok && (ifc.lo_wdata === e.e_ld);
`ifndef WB_DEBUG_TRACE_EN
        ok = ok && (ifc.dbg_reg_we === 4'd0) && (ifc.dbg_waddr === 5'd0) &&
             (ifc.dbg_wdata === 32'd0) && (ifc.dbg_pc === 32'd0);
`endif
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got mr=%b st=%b rf=%b/%0d/%h hi=%b/%h lo=%b/%h dbg=%h, want mr=%b st=%b rf=%b/%0d/%h hi=%b/%h lo=%b/%h",
                     name, ifc.m_ready, ifc.p_stall, ifc.rf_we, ifc.rf_waddr,
                     ifc.rf_wdata, ifc.hi_we, ifc.hi_wdata, ifc.lo_we,
                     ifc.lo_wdata, ifc.dbg_reg_we, e.e_mr, e.e_st, e.e_rf,
                     e.e_ra, e.e_rd, e.e_hi, e.e_hd, e.e_lo, e.e_ld);
        end
    endtask

    task automatic step(input string name, input vec_t e);
        drive(e);
        @(negedge clk);
        check(name, e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && ifc.p_stall) begin
            tests++;
            if (ifc.p_valid) begin
                fails++;
                $display("FAIL stall_pv: got p_valid=%b during p_stall, want 0",
                         ifc.p_valid);
            end
        end
`ifndef WB_DEBUG_TRACE_EN
        if (ifc.dbg_reg_we !== 4'd0 || ifc.dbg_waddr !== 5'd0 ||
            ifc.dbg_wdata !== 32'd0 || ifc.dbg_pc !== 32'd0)
            dbg_bad++;
`endif
    end

    initial begin
        vec_t idle0;
        vec_t idle1;
        tests   = 0;
        fails   = 0;
        dbg_bad = 0;
        idle0 = v(0,0,0,0,0,0, 0,0,0,0,0,0, 0,0, 0,0,0, 0,0, 0,0);
        idle1 = v(0,0,0,0,0,0, 0,0,0,0,0,0, 1,0, 0,0,0, 0,0, 0,0);

        // single push drains one cycle after entry
        vq.push_back(idle1);
        vq.push_back(v(0,0,0,0,0,0, 1,1,0,0,5,'h1234, 1,0, 0,0,0, 0,0, 0,0));
        vq.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0, 1,0, 1,5,'h1234, 0,0, 0,0));
        // reg conflict defers head until pipeline stops writing regs
        vq.push_back(v(0,0,0,0,0,0, 1,1,0,0,7,'h77, 1,0, 0,0,0, 0,0, 0,0));
        vq.push_back(v(1,1,0,0,3,'h33, 0,0,0,0,0,0, 1,0, 1,3,'h33, 0,0, 0,0));
        vq.push_back(v(1,0,1,0,0,'h50, 0,0,0,0,0,0, 1,0, 1,7,'h77, 1,'h51, 0,0));
        // head HI write alongside pipeline reg write
        vq.push_back(v(0,0,0,0,0,0, 1,0,1,0,0,'h900, 1,0, 0,0,0, 0,0, 0,0));
        vq.push_back(v(1,1,0,0,4,'h44, 0,0,0,0,0,0, 1,0, 1,4,'h44, 1,'h901, 0,0));
        // reg 0 target consumed without write
        vq.push_back(v(0,0,0,0,0,0, 1,1,0,0,0,'hdead, 1,0, 0,0,0, 0,0, 0,0));
        vq.push_back(idle1);
        vq.push_back(v(0,0,0,0,0,0, 1,1,0,0,9,'h99, 1,0, 0,0,0, 0,0, 0,0));
        vq.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0, 1,0, 1,9,'h99, 0,0, 0,0));
        vq.push_back(idle1);
        // starvation: full FIFO, stall pulse, forced drain
        vq.push_back(v(1,1,0,0,1,'h10, 1,1,0,0,2,'h20, 1,0, 1,1,'h10, 0,0, 0,0));
        vq.push_back(v(1,1,0,0,1,'h11, 1,1,0,0,3,'h30, 1,0, 1,1,'h11, 0,0, 0,0));
        vq.push_back(v(1,1,0,0,1,'h12, 1,1,0,0,4,'h40, 0,0, 1,1,'h12, 0,0, 0,0));
        vq.push_back(v(1,1,0,0,1,'h13, 1,1,0,0,4,'h40, 0,0, 1,1,'h13, 0,0, 0,0));
        vq.push_back(v(0,0,0,0,0,0, 1,1,0,0,4,'h40, 0,1, 1,2,'h20, 0,0, 0,0));
        vq.push_back(v(1,1,0,0,1,'h14, 1,1,0,0,4,'h40, 1,0, 1,1,'h14, 0,0, 0,0));
        vq.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0, 0,0, 1,3,'h30, 0,0, 0,0));
        vq.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0, 1,0, 1,4,'h40, 0,0, 0,0));
        vq.push_back(idle1);
        // LO conflict
        vq.push_back(v(0,0,0,0,0,0, 1,0,0,1,0,'h600, 1,0, 0,0,0, 0,0, 0,0));
        vq.push_back(v(1,0,0,1,0,'h70, 0,0,0,0,0,0, 1,0, 0,0,0, 0,0, 1,'h72));
        vq.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0, 1,0, 0,0,0, 0,0, 1,'h602));
        vq.push_back(idle1);

        rst = 1'b0;
        drive(idle0);
        @(posedge clk);
        #1;
        step("reset0", idle0);
        step("reset1", idle0);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++)
            step($sformatf("vec%0d", i), vq[i]);

        // reset with two entries buffered discards them
        step("r33a", v(1,1,0,0,1,'h15, 1,1,0,0,2,'h22, 1,0, 1,1,'h15, 0,0, 0,0));
        step("r33b", v(1,1,0,0,1,'h16, 1,1,0,0,3,'h33, 1,0, 1,1,'h16, 0,0, 0,0));
        rst = 1'b0;
        step("r33_rst0", idle0);
        step("r33_rst1", idle0);
        rst = 1'b1;
        step("r33_rel0", idle1);
        step("r33_rel1", idle1);
        step("r33_rel2", idle1);

`ifndef WB_DEBUG_TRACE_EN
        tests++;
        if (dbg_bad != 0) begin
            fails++;
            $display("FAIL dbg_tied: got %0d nonzero dbg samples, want 0", dbg_bad);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
